// File: rtl/sram_model_pkg.sv
// Shared helpers for the synchronous SRAM model family (lane math, merge, counter width).
// Latency: none, functions and constants only.
// Backpressure: not applicable.
package sram_model_pkg;

  // Width of the saturating read/write collision counter.
  localparam int COLL_CNT_W = 16;

  // Number of write-mask lanes for a given word and lane width.
  function automatic int num_wmasks(input int data_width, input int write_size);
    return data_width / write_size;
  endfunction

  // Bit-level lane merge: takes the new bit when its lane is enabled, else keeps the old bit.
  function automatic logic lane_merge(input logic old_bit, input logic new_bit, input logic lane_en);
    return lane_en ? new_bit : old_bit;
  endfunction

endpackage

// File: rtl/sram_wmask_merge.sv
// Byte-lane merge of an old word with write data under a lane mask.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module sram_wmask_merge
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WRITE_SIZE = 8
) (
  input  logic [DATA_WIDTH-1:0]                           old_word,
  input  logic [DATA_WIDTH-1:0]                           din,
  input  logic [num_wmasks(DATA_WIDTH, WRITE_SIZE)-1:0]   wmask,
  output logic [DATA_WIDTH-1:0]                           merged
);

  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);

  for (genvar l = 0; l < NUM_WMASKS; l++) begin : g_lane
    for (genvar k = 0; k < WRITE_SIZE; k++) begin : g_bit
      assign merged[l*WRITE_SIZE + k] =
        lane_merge(old_word[l*WRITE_SIZE + k], din[l*WRITE_SIZE + k], wmask[l]);
    end
  end

endmodule

// File: rtl/sram_1rwnr_sync_model.sv
// Single-clock SRAM model: one RW port, NUM_R_PORTS read ports, lane mask, collision counter; SRAM_RW_BYPASS_EN selects write-through on collisions.
// Latency: request sampled at edge E, write commits at E+1, read data valid after E+READ_LATENCY (1 or 2).
// Backpressure: none, every port accepts one request per cycle; valids pulse for one cycle, dout holds otherwise.
module sram_1rwnr_sync_model
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int WRITE_SIZE   = 8,
  parameter int NUM_R_PORTS  = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                                          clk0,
  input  logic                                          rstb,
  input  logic                                          csb0,
  input  logic                                          web0,
  input  logic [num_wmasks(DATA_WIDTH, WRITE_SIZE)-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]                         addr0,
  input  logic [DATA_WIDTH-1:0]                         din0,
  output logic [DATA_WIDTH-1:0]                         dout0,
  output logic                                          dout0_valid,
  input  logic [NUM_R_PORTS-1:0]                        csb1,
  input  logic [NUM_R_PORTS*ADDR_WIDTH-1:0]             addr1,
  output logic [NUM_R_PORTS*DATA_WIDTH-1:0]             dout1,
  output logic [NUM_R_PORTS-1:0]                        dout1_valid,
  output logic [COLL_CNT_W-1:0]                         collision_count
);

  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  // Read lanes: lane 0 is port 0, lane i+1 is read-only port i.
  localparam int NUM_RD     = NUM_R_PORTS + 1;

  // Request stage
  logic                            csb0_q;
  logic                            web0_q;
  logic [NUM_WMASKS-1:0]           wmask0_q;
  logic [ADDR_WIDTH-1:0]           addr0_q;
  logic [DATA_WIDTH-1:0]           din0_q;
  logic [NUM_R_PORTS-1:0]          csb1_q;
  logic [NUM_R_PORTS*ADDR_WIDTH-1:0] addr1_q;

  // Capture all port requests; reset parks every port idle and drops a pending write.
  always_ff @(posedge clk0) begin
    if (!rstb) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      csb1_q   <= '1;
      addr1_q  <= '0;
    end else begin
      csb0_q   <= csb0;
      web0_q   <= web0;
      wmask0_q <= wmask0;
      addr0_q  <= addr0;
      din0_q   <= din0;
      csb1_q   <= csb1;
      addr1_q  <= addr1;
    end
  end

  // Storage and decode
  logic [DATA_WIDTH-1:0]                 mem [DEPTH];
  logic                                  wr_en;
  logic [DATA_WIDTH-1:0]                 wr_old;
  logic [DATA_WIDTH-1:0]                 wr_merged;
  logic [NUM_RD-1:0]                     rd_en;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]     rd_addr;
  logic [NUM_R_PORTS-1:0]                collide;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_word;

  assign wr_en  = !csb0_q && !web0_q;
  assign wr_old = mem[addr0_q];

  // The merged word feeds the array write and, since a colliding read shares the address, the bypass too.
  sram_wmask_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_SIZE (WRITE_SIZE)
  ) u_merge (
    .old_word (wr_old),
    .din      (din0_q),
    .wmask    (wmask0_q),
    .merged   (wr_merged)
  );

  // Decode registered requests into per-lane read enables, addresses and collision flags.
  always_comb begin
    rd_en      = '0;
    rd_addr    = '0;
    collide    = '0;
    rd_en[0]   = !csb0_q && web0_q;
    rd_addr[0] = addr0_q;
    for (int i = 0; i < NUM_R_PORTS; i++) begin
      rd_en[i+1]   = !csb1_q[i];
      rd_addr[i+1] = addr1_q[i*ADDR_WIDTH +: ADDR_WIDTH];
      collide[i]   = wr_en && !csb1_q[i] &&
                     (addr1_q[i*ADDR_WIDTH +: ADDR_WIDTH] == addr0_q);
    end
  end

  // Commit the write; the array is never reset, and a reset on the commit edge drops the write.
  always_ff @(posedge clk0) begin
    if (rstb && wr_en) begin
      mem[addr0_q] <= wr_merged;
    end
  end

  // Array read is read-before-write; the bypass build substitutes the merged word on a collision.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = mem[rd_addr[p]];
    end
`ifdef SRAM_RW_BYPASS_EN
    for (int i = 0; i < NUM_R_PORTS; i++) begin
      if (collide[i]) begin
        rd_word[i+1] = wr_merged;
      end
    end
`endif
  end

  // Collision counter
  logic [COLL_CNT_W:0] coll_sum;

  // Add one per colliding read port; the extra top bit flags overflow for saturation.
  always_comb begin
    coll_sum = {1'b0, collision_count};
    for (int i = 0; i < NUM_R_PORTS; i++) begin
      coll_sum = coll_sum + (COLL_CNT_W+1)'(collide[i]);
    end
  end

  // Saturating collision count register.
  always_ff @(posedge clk0) begin
    if (!rstb) begin
      collision_count <= '0;
    end else if (coll_sum[COLL_CNT_W]) begin
      collision_count <= '1;
    end else begin
      collision_count <= coll_sum[COLL_CNT_W-1:0];
    end
  end

  // Read pipeline
  logic [NUM_RD-1:0]                 s1_vld;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] s1_dat;
  logic [NUM_RD-1:0]                 out_vld;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] out_dat;

  // First read register: data updates only for active lanes so idle lanes hold.
  always_ff @(posedge clk0) begin
    if (!rstb) begin
      s1_vld <= '0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          s1_dat[p] <= rd_word[p];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic [NUM_RD-1:0]                 s2_vld;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] s2_dat;

    // Extra output register; data holds between valid pulses.
    always_ff @(posedge clk0) begin
      if (!rstb) begin
        s2_vld <= '0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        for (int p = 0; p < NUM_RD; p++) begin
          if (s1_vld[p]) begin
            s2_dat[p] <= s1_dat[p];
          end
        end
      end
    end

    assign out_vld = s2_vld;
    assign out_dat = s2_dat;
  end else begin : g_rl1
    assign out_vld = s1_vld;
    assign out_dat = s1_dat;
  end

  assign dout0       = out_dat[0];
  assign dout0_valid = out_vld[0];

  for (genvar i = 0; i < NUM_R_PORTS; i++) begin : g_rport
    assign dout1[i*DATA_WIDTH +: DATA_WIDTH] = out_dat[i+1];
    assign dout1_valid[i]                    = out_vld[i+1];
  end

endmodule

// File: tb/tb_sram_1rwnr_sync_model.sv
// Directed self-checking bench for sram_1rwnr_sync_model with two read ports.
// Latency: expectations are aligned to READ_LATENCY edges after the sampling edge.
// Backpressure: none; stimulus is applied one request per cycle.
module tb_sram_1rwnr_sync_model;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int WS = 8;
  localparam int NR = 2;
  localparam int RL = 2;

`ifdef SRAM_RW_BYPASS_EN
  localparam logic [31:0] EXP_COLL_A = 32'h1234_5678;
  localparam logic [31:0] EXP_COLL_B = 32'h1234_BE78;
`else
  localparam logic [31:0] EXP_COLL_A = 32'h0BAD_F00D;
  localparam logic [31:0] EXP_COLL_B = 32'h1234_5678;
`endif

  logic             clk0 = 1'b0;
  logic             rstb;
  logic             csb0;
  logic             web0;
  logic [3:0]       wmask0;
  logic [AW-1:0]    addr0;
  logic [DW-1:0]    din0;
  logic [DW-1:0]    dout0;
  logic             dout0_valid;
  logic [NR-1:0]    csb1;
  logic [NR*AW-1:0] addr1;
  logic [NR*DW-1:0] dout1;
  logic [NR-1:0]    dout1_valid;
  logic [15:0]      collision_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk0 = ~clk0;

  sram_1rwnr_sync_model #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .WRITE_SIZE   (WS),
    .NUM_R_PORTS  (NR),
    .READ_LATENCY (RL)
  ) dut (
    .clk0            (clk0),
    .rstb            (rstb),
    .csb0            (csb0),
    .web0            (web0),
    .wmask0          (wmask0),
    .addr0           (addr0),
    .din0            (din0),
    .dout0           (dout0),
    .dout0_valid     (dout0_valid),
    .csb1            (csb1),
    .addr1           (addr1),
    .dout1           (dout1),
    .dout1_valid     (dout1_valid),
    .collision_count (collision_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = 4'h0;
    addr0  = '0;
    din0   = '0;
    csb1   = 2'b11;
    addr1  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = a;
  endtask

  initial begin
    idle();
    rstb = 1'b0;
    cyc(2);
    check_eq("rst0_dout0",  dout0, 0);
    check_eq("rst0_vld0",   dout0_valid, 0);
    check_eq("rst0_dout1",  dout1, 0);
    check_eq("rst0_vld1",   dout1_valid, 0);
    check_eq("rst0_count",  collision_count, 0);
    rstb = 1'b1;

    // Fill: full write, masked write, two more full words.
    wr(10'd5, 32'hAABB_CCDD, 4'hF);  cyc(1);
    wr(10'd5, 32'h1122_3344, 4'b0101); cyc(1);
    wr(10'd6, 32'h6666_6666, 4'hF);  cyc(1);
    wr(10'd9, 32'h0BAD_F00D, 4'hF);  cyc(1);
    check_eq("wr_no_vld0", dout0_valid, 0);

    // Port 0 read of the masked word, latency and hold.
    idle(); rd0(10'd5); cyc(1); idle();
    cyc(RL - 1);
    check_eq("rd0_early_vld", dout0_valid, 0);
    cyc(1);
    check_eq("rd0_vld",   dout0_valid, 1);
    check_eq("rd0_data",  dout0, 32'hAA22_CC44);
    cyc(1);
    check_eq("rd0_vld_drop", dout0_valid, 0);
    check_eq("rd0_hold",     dout0, 32'hAA22_CC44);

    // Both read ports plus port 0 on the same address: no collision.
    rd0(10'd5); csb1 = 2'b00; addr1 = {10'd6, 10'd5}; cyc(1); idle();
    cyc(RL);
    check_eq("mp_vld1",   dout1_valid, 2'b11);
    check_eq("mp_dout1",  dout1, {32'h6666_6666, 32'hAA22_CC44});
    check_eq("mp_vld0",   dout0_valid, 1);
    check_eq("mp_dout0",  dout0, 32'hAA22_CC44);
    check_eq("mp_count",  collision_count, 0);
    cyc(1);
    check_eq("mp_vld1_drop", dout1_valid, 2'b00);
    check_eq("mp_hold1",     dout1, {32'h6666_6666, 32'hAA22_CC44});

    // Full-word collision on port 1.
    wr(10'd9, 32'h1234_5678, 4'hF); csb1 = 2'b00; addr1 = {10'd6, 10'd9}; cyc(1); idle();
    cyc(1);
    check_eq("colA_count", collision_count, 1);
    cyc(RL - 1);
    check_eq("colA_vld1",  dout1_valid, 2'b11);
    check_eq("colA_dout1", dout1, {32'h6666_6666, EXP_COLL_A});
    rd0(10'd9); cyc(1); idle(); cyc(RL);
    check_eq("colA_after", dout0, 32'h1234_5678);

    // Masked collision on port 2 only.
    wr(10'd9, 32'hDEAD_BEEF, 4'b0010); csb1 = 2'b01; addr1 = {10'd9, 10'd6}; cyc(1); idle();
    cyc(1);
    check_eq("colB_count", collision_count, 2);
    cyc(RL - 1);
    check_eq("colB_vld1",  dout1_valid, 2'b10);
    check_eq("colB_dout2", dout1[63:32], EXP_COLL_B);

    // Zero-mask write still collides with both ports and leaves the word intact.
    wr(10'd9, 32'hFFFF_FFFF, 4'b0000); csb1 = 2'b00; addr1 = {10'd9, 10'd9}; cyc(1); idle();
    cyc(1);
    check_eq("colC_count", collision_count, 4);
    cyc(RL - 1);
    check_eq("colC_dout1", dout1, {32'h1234_BE78, 32'h1234_BE78});
    rd0(10'd9); cyc(1); idle(); cyc(RL);
    check_eq("colC_after", dout0, 32'h1234_BE78);

    // Write sampled, then reset on its commit edge with activity on all ports.
    wr(10'd5, 32'h5555_5555, 4'hF); cyc(1);
    rstb = 1'b0;
    wr(10'd5, 32'h7777_7777, 4'hF); csb1 = 2'b00; addr1 = {10'd5, 10'd5};
    cyc(2);
    check_eq("rst1_dout0", dout0, 0);
    check_eq("rst1_vld0",  dout0_valid, 0);
    check_eq("rst1_dout1", dout1, 0);
    check_eq("rst1_vld1",  dout1_valid, 0);
    check_eq("rst1_count", collision_count, 0);
    idle(); rstb = 1'b1;
    rd0(10'd5); cyc(1); idle(); cyc(RL);
    check_eq("rst1_vld_rd", dout0_valid, 1);
    check_eq("rst1_nowr",   dout0, 32'hAA22_CC44);

    // Two collisions per cycle until the counter saturates.
    wr(10'd9, 32'h0, 4'hF); csb1 = 2'b00; addr1 = {10'd9, 10'd9};
    cyc(100);
    check_eq("sat_198",  collision_count, 16'd198);
    cyc(32668);
    check_eq("sat_fffe", collision_count, 16'hFFFE);
    cyc(1);
    check_eq("sat_ffff", collision_count, 16'hFFFF);
    cyc(3);
    check_eq("sat_hold", collision_count, 16'hFFFF);
    idle();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1rwnr_sync_model.md
# sram_1rwnr_sync_model

Parametrised single-clock OpenRAM-style SRAM model: one read/write port (port 0) plus NUM_R_PORTS read-only ports (port 1..), byte-lane write mask, selectable read latency and synchronous reset of all control and output state. Successor to the fixed 32x1024 1rw1r model: generalised in width, depth and read-port count, synthesizable (no `#` delays, no X injection), with read-during-write collision counting and optional write-to-read bypass. Sits behind macro wrappers in RTL sims and FPGA prototypes wherever a hard macro is substituted.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of WRITE_SIZE
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
- WRITE_SIZE, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WRITE_SIZE
- NUM_R_PORTS, 1, read-only ports, 1..4
- READ_LATENCY, 1, edges from sampled request to dout, 1 or 2
- clk0  in  1  single clock, all ports
- rstb  in  1  reset, synchronous, active-low
- csb0  in  1  port 0 select, active-low
- web0  in  1  port 0 write enable, active-low
- wmask0  in  NUM_WMASKS  lane enables, 1 = write lane
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_valid  out  1  dout0 updated this cycle
- csb1  in  NUM_R_PORTS  read-port selects, active-low, bit i = port i
- addr1  in  NUM_R_PORTS*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- dout1  out  NUM_R_PORTS*DATA_WIDTH  read data, same packing
- dout1_valid  out  NUM_R_PORTS  per-port valid
- collision_count  out  16  saturating count of same-address write/read collisions

## Operation
- Edge E: all inputs captured into request registers (csb, web, wmask, addr, din).
- Write (csb0=0, web0=0): at edge E+1 mem[addr0] lanes with wmask bit set take din0 lanes; others unchanged. wmask0=0 is a legal no-op write (still counts for collisions).
- Read port 0 (csb0=0, web0=1) / port i (csb1[i]=0): array read from registered address; data at dout after READ_LATENCY edges, with valid pulsed for exactly that cycle.
- Idle or write on port 0: dout0 holds last value, dout0_valid=0. Idle port i: dout1 slice holds, valid bit 0.
- Collision: registered write on port 0 and registered read on port i to the same address in the same cycle; counter +1 per colliding read port (up to NUM_R_PORTS per cycle), saturates at 16'hFFFF.
- Read data without bypass = pre-write contents (read-before-write).
- Memory array is never reset; power-up contents undefined in sim, uninitialised in synthesis.
- Reset (rstb=0 at an edge): request registers cleared to idle, pending write in the request stage dropped, pipeline stage cleared, dout0/dout1 = 0, all valids = 0, collision_count = 0. First request sampled on the first edge with rstb=1.
- Port 0 read and port i read of the same address: no conflict, no count.

## Timing
- READ_LATENCY=1: request at edge E, dout valid after edge E+1.
- READ_LATENCY=2: extra output register; valid after edge E+2; dout holds between valids.
- Write visible to any read sampled at edge >= E+1 (written at E+1, read registered at E+1 reads new data at E+2).
- Back-to-back requests every cycle on all ports; throughput 1 per port per cycle.
- collision_count updates at edge E+1 for requests sampled at E.

## Configuration
- SRAM_RW_BYPASS_EN defined: a colliding read returns the write-merged word (din0 lanes where wmask set, old lanes elsewhere), i.e. write-through.
- Undefined: colliding read returns old contents. Collision counting is identical in both builds.

## Structure
- Package sram_model_pkg: localparam functions num_wmasks(DATA_WIDTH, WRITE_SIZE), lane-merge function, collision counter width constant (16).
- Sub-module sram_wmask_merge: combinational lane merge of old word, din, mask; used by the write path and the bypass path.

## Test plan
- Reset: drive rstb=0 two edges with activity on all ports -> all douts 0, all valids 0, collision_count 0; no write lands.
- Masked write: write addr0=5 din0=32'hAABBCCDD wmask0=4'hF, then wmask0=4'b0101 din0=32'h11223344, read port0 addr 5 -> 32'hAA22CC44 with dout0_valid one cycle, after READ_LATENCY edges.
- Multi-port read (NUM_R_PORTS=2): ports 1,2 read addr 5 and 6 the same cycle -> both slices correct, both valid bits pulse together.
- Collision: write addr 9 din 32'h12345678 while port1 reads addr 9 -> collision_count=1; dout1 = old word without SRAM_RW_BYPASS_EN, 32'h12345678 with it.
- Saturation: 65540 consecutive collisions -> collision_count stops at 16'hFFFF.
- Reset mid-write: write sampled at edge E, rstb=0 at E+1 -> subsequent read of that address returns prior contents.
